// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU (ADD only) for WIDTH iterations.
// Optional: define ALU_MUL_SEQUENCER_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [3:0]       ALUCntrlOperation,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALUResult
);

  localparam logic [3:0]       ALU_OP_ADD = 4'd2;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);

  // Handshake: Start is a level request sampled only in IDLE; Busy covers RUN and DONE,
  // and Done is a single-cycle completion pulse with Product already updated.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_iter;

`ifdef ALU_MUL_SEQUENCER_EARLY_EXIT_EN
  // No set bits left above the current one: this partial product is the final sum.
  assign last_iter = ((mplier_q >> 1) == '0) || (count_q == LAST_CNT);
`else
  assign last_iter = (count_q == LAST_CNT);
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    mcand_d           = mcand_q;
    mplier_d          = mplier_q;
    acc_d             = acc_q;
    count_d           = count_q;
    product_d         = product_q;
    ALUCntrlOperation = ALU_OP_ADD;
    ALU_A             = '0;
    ALU_B             = '0;
    Busy              = 1'b0;
    Done              = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mcand_d  = Multiplicand;
          mplier_d = Multiplier;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        Busy     = 1'b1;
        ALU_A    = acc_q;
        ALU_B    = mplier_q[0] ? mcand_q : '0;
        // The ALU sum wraps at WIDTH bits; the carry-out is deliberately dropped.
        acc_d    = ALUResult;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (last_iter) begin
          product_d = ALUResult;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the shared ALU and predicts products/latencies with plain arithmetic.
// Honours ALU_MUL_SEQUENCER_EARLY_EXIT_EN when predicting Done timing.
module tb_alu_mul_sequencer;

  localparam int W = 64;

  logic          CLOCK;
  logic          RESET;
  logic          Start;
  logic [W-1:0]  Multiplicand;
  logic [W-1:0]  Multiplier;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Product;
  logic [3:0]    ALUCntrlOperation;
  logic [W-1:0]  ALU_A;
  logic [W-1:0]  ALU_B;
  logic [W-1:0]  ALUResult;

  int            vec_count;
  int            err_count;
  logic [W-1:0]  model_prod;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .CLOCK             (CLOCK),
    .RESET             (RESET),
    .Start             (Start),
    .Multiplicand      (Multiplicand),
    .Multiplier        (Multiplier),
    .Busy              (Busy),
    .Done              (Done),
    .Product           (Product),
    .ALUCntrlOperation (ALUCntrlOperation),
    .ALU_A             (ALU_A),
    .ALU_B             (ALU_B),
    .ALUResult         (ALUResult)
  );

  // Shared ALU: only ADD is meaningful here; anything else returns a poison value.
  assign ALUResult = (ALUCntrlOperation == 4'd2) ? (ALU_A + ALU_B) : 64'hDEAD_BEEF_DEAD_BEEF;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Cycle (counting the cycle after the accepting edge as 1) in which Done is expected.
  function automatic int exp_done_cycle(input logic [W-1:0] b);
    int k;
    k = W;
`ifdef ALU_MUL_SEQUENCER_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
`endif
    return 1 + k;
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    Start = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    vec_count++; if (Busy !== 1'b0) begin err_count++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vec_count++; if (Done !== 1'b0) begin err_count++; $display("FAIL reset_done: got %b want 0", Done); end
    vec_count++; if (Product !== '0) begin err_count++; $display("FAIL reset_product: got %h want 0", Product); end
    vec_count++; if (ALUCntrlOperation !== 4'd2) begin err_count++; $display("FAIL reset_aluop: got %0d want 2", ALUCntrlOperation); end
    vec_count++; if (ALU_A !== '0 || ALU_B !== '0) begin err_count++; $display("FAIL reset_alu_operands: got %h/%h want 0/0", ALU_A, ALU_B); end
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_prod = '0;
  endtask

  // One job from IDLE; optional stray Start pulse (with other operands) during cycle pulse_at.
  task automatic run_job(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
    int lat, first_done, done_cnt, busy_bad, op_bad, early_chg;
    logic busy_after;
    logic [W-1:0] prod_at_done, exp;
    lat = exp_done_cycle(b);
    exp = a * b;
    first_done = 0; done_cnt = 0; busy_bad = 0; op_bad = 0; early_chg = 0;
    busy_after = 1'bx; prod_at_done = 'x;
    @(negedge CLOCK);
    Start = 1'b1; Multiplicand = a; Multiplier = b;
    @(posedge CLOCK); #1;
    Start = 1'b0; Multiplicand = rand64(); Multiplier = rand64();
    for (int c = 1; c <= lat + 1; c++) begin
      if (c == pulse_at) begin Start = 1'b1; Multiplicand = 64'd2; Multiplier = 64'd2; end
      @(negedge CLOCK);
      if (Done === 1'b1) begin done_cnt++; if (first_done == 0) first_done = c; end
      if (ALUCntrlOperation !== 4'd2) op_bad++;
      if (Done === 1'b1 && (ALU_A !== '0 || ALU_B !== '0)) op_bad++;
      if (c <= lat && Busy !== 1'b1) busy_bad++;
      if (c < lat && Product !== model_prod) early_chg++;
      if (c == lat) prod_at_done = Product;
      if (c == lat + 1) busy_after = Busy;
      @(posedge CLOCK); #1;
      Start = 1'b0;
    end
    model_prod = exp;
    vec_count++; if (first_done != lat) begin err_count++; $display("FAIL %s done_cycle: got %0d want %0d", name, first_done, lat); end
    vec_count++; if (done_cnt != 1) begin err_count++; $display("FAIL %s done_width: got %0d want 1", name, done_cnt); end
    vec_count++; if (prod_at_done !== exp) begin err_count++; $display("FAIL %s product: got %h want %h", name, prod_at_done, exp); end
    vec_count++; if (busy_bad != 0) begin err_count++; $display("FAIL %s busy_low_while_active: got %0d cycles want 0", name, busy_bad); end
    vec_count++; if (busy_after !== 1'b0) begin err_count++; $display("FAIL %s busy_after_done: got %b want 0", name, busy_after); end
    vec_count++; if (op_bad != 0) begin err_count++; $display("FAIL %s alu_drive: got %0d bad cycles want 0", name, op_bad); end
    vec_count++; if (early_chg != 0) begin err_count++; $display("FAIL %s product_changed_early: got %0d cycles want 0", name, early_chg); end
  endtask

  task automatic test_directed();
    run_job("mul_3x5", 64'd3, 64'd5, 0);
    run_job("wrap_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    run_job("pow32_sq", 64'h1_0000_0000, 64'h1_0000_0000, 0);
    run_job("zero_mplier", 64'h1234, 64'd0, 0);
    run_job("one_mplier", 64'hABCD, 64'd1, 0);
    run_job("msb_mplier", 64'd1, 64'h8000_0000_0000_0000, 0);
  endtask

  task automatic test_start_ignored();
    run_job("start_in_run", 64'd7, 64'd9, 10);
  endtask

  task automatic test_reset_abort();
    int done_seen, busy_seen;
    done_seen = 0; busy_seen = 0;
    @(negedge CLOCK);
    Start = 1'b1; Multiplicand = 64'd7; Multiplier = 64'd9;
    @(posedge CLOCK); #1;
    Start = 1'b0;
    repeat (29) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    #1;
    vec_count++; if (Busy !== 1'b0) begin err_count++; $display("FAIL abort_busy: got %b want 0", Busy); end
    vec_count++; if (Done !== 1'b0) begin err_count++; $display("FAIL abort_done: got %b want 0", Done); end
    vec_count++; if (Product !== '0) begin err_count++; $display("FAIL abort_product: got %h want 0", Product); end
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_prod = '0;
    for (int c = 0; c < 70; c++) begin
      @(negedge CLOCK);
      if (Done !== 1'b0) done_seen++;
      if (Busy !== 1'b0) busy_seen++;
    end
    vec_count++; if (done_seen != 0) begin err_count++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    vec_count++; if (busy_seen != 0) begin err_count++; $display("FAIL abort_stays_idle: got %0d busy cycles want 0", busy_seen); end
    run_job("after_abort_4x4", 64'd4, 64'd4, 0);
  endtask

  // Start held high across two jobs: exactly one idle cycle separates them.
  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int d1, d2, done_bad, busy_bad;
    logic [W-1:0] p1, p2;
    a1 = rand64(); b1 = rand64() >> $urandom_range(0, 63);
    a2 = rand64(); b2 = rand64() >> $urandom_range(0, 63);
    d1 = exp_done_cycle(b1);
    d2 = d1 + 1 + exp_done_cycle(b2);
    done_bad = 0; busy_bad = 0; p1 = 'x; p2 = 'x;
    @(negedge CLOCK);
    Start = 1'b1; Multiplicand = a1; Multiplier = b1;
    @(posedge CLOCK); #1;
    Multiplicand = a2; Multiplier = b2;
    for (int c = 1; c <= d2 + 1; c++) begin
      @(negedge CLOCK);
      if (Done !== ((c == d1) || (c == d2))) done_bad++;
      if (Busy !== ((c != d1 + 1) && (c <= d2))) busy_bad++;
      if (c == d1) p1 = Product;
      if (c == d2) p2 = Product;
      @(posedge CLOCK); #1;
      if (c == d2) Start = 1'b0;
    end
    Start = 1'b0;
    model_prod = a2 * b2;
    vec_count++; if (done_bad != 0) begin err_count++; $display("FAIL b2b_done_timing: got %0d bad cycles want 0", done_bad); end
    vec_count++; if (busy_bad != 0) begin err_count++; $display("FAIL b2b_busy_timing: got %0d bad cycles want 0", busy_bad); end
    vec_count++; if (p1 !== a1 * b1) begin err_count++; $display("FAIL b2b_product1: got %h want %h", p1, a1 * b1); end
    vec_count++; if (p2 !== a2 * b2) begin err_count++; $display("FAIL b2b_product2: got %h want %h", p2, a2 * b2); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = rand64();
      b = rand64() >> $urandom_range(0, 63);
      run_job($sformatf("random_%0d", i), a, b, $urandom_range(0, 3) == 0 ? $urandom_range(2, 20) : 0);
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    model_prod = '0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
